// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, bus encodings,
// FIFO depth and the fetch FSM state encoding.
package ifetch_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int IFETCH_DEPTH = 2;

  // Bus transfer size code for a full-word access.
  localparam logic [2:0] BUS_FULL = 3'b010;

  typedef enum logic {
    IFETCH_RUN  = 1'b0,
    IFETCH_DROP = 1'b1
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Two-entry FIFO of {pc, inst} pairs sitting between the instruction bus and
// decode. Flush wins over push and pop; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [IFETCH_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(IFETCH_DEPTH)) || do_pop);

  // Storage, pointers and occupancy; reset also clears the data so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < IFETCH_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word reads on the instruction bus, buffers the
// returned words in a 2-entry FIFO and handles redirects. A redirect that
// lands while a read is outstanding moves to DROP, which keeps the old
// request on the bus until its ack arrives and throws that data away.
//
// state       | meaning
// IFETCH_RUN  | normal fetch, acks are pushed into the FIFO
// IFETCH_DROP | outstanding read belongs to a stale PC; its ack is discarded
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_addr,
  output logic [2:0]      bus_opt,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifetch_state_t     state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   drop_addr;
  logic [XLEN-1:0]   redirect_aligned;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] fifo_dout;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // While a stale read is in flight, the bus keeps seeing its original address.
  assign bus_req  = !rst && ((state == IFETCH_DROP) || (count < 2'(IFETCH_DEPTH)));
  assign bus_addr = (state == IFETCH_DROP) ? drop_addr : fetch_pc;
  assign bus_opt  = BUS_FULL;

  assign inst_valid = !rst && (count != 2'd0);
  assign inst       = rst ? '0 : fifo_dout[XLEN-1:0];
  assign inst_pc    = rst ? '0 : fifo_dout[2*XLEN-1:XLEN];

  // A redirect voids both the push and the pop of its cycle.
  assign push = (state == IFETCH_RUN) && bus_req && bus_ack && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  fetch_fifo #(.W(2*XLEN)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({fetch_pc, bus_rdata}),
    .dout  (fifo_dout),
    .count (count)
  );

  // Fetch FSM and fetch PC tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IFETCH_RUN;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
    end else begin
      case (state)
        IFETCH_RUN: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            if (bus_req && !bus_ack) begin
              state     <= IFETCH_DROP;
              drop_addr <= fetch_pc;
            end
          end else if (push) begin
            fetch_pc <= fetch_pc + XLEN'(4);
          end
        end
        IFETCH_DROP: begin
          if (redirect_valid) fetch_pc <= redirect_aligned;
          if (bus_ack) state <= IFETCH_RUN;
        end
        default: state <= IFETCH_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, hand-written multi-cycle corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [2:0]  bus_opt;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic [2:0]  w_opt;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_opt        (bus_opt),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .bus_req        (w_req),
    .bus_addr       (w_addr),
    .bus_opt        (w_opt),
    .bus_ack        (w_ack),
    .bus_rdata      (w_rdata),
    .inst           (w_inst),
    .inst_pc        (w_pc),
    .inst_valid     (w_valid),
    .inst_ready     (w_ready),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One row = inputs held for a cycle plus the outputs expected in that cycle.
  typedef struct {
    logic        rst, ack, ready, redir;
    logic [31:0] rpc, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic a, logic rdy, logic rd, logic [31:0] rpc,
                              logic [31:0] rdata, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.ack = a; v.ready = rdy; v.redir = rd; v.rpc = rpc; v.rdata = rdata;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic drive(input logic r, input logic a, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    rst = r; bus_ack = a; inst_ready = rdy; redirect_valid = rd;
    redirect_pc = rpc; bus_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetched words as a queue, plus the fetch PC and a
  // "stale read in flight" flag with the address that read was issued to.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch;
  bit          m_drop;
  logic [31:0] m_drop_addr;

  initial begin
    bit          m_req;
    logic [31:0] m_addr;
    bit          m_valid;
    bit          ack_ok;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    w_rst = 1'b1; w_ack = 1'b0; w_ready = 1'b0; w_rdata = 32'h0;

    // Directed table: streaming, backpressure, redirect together with ack.
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,32'hA0,        1,32'h0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,32'hA4,        1,32'h4,1,32'h0,32'hA0));
    vecs.push_back(mk(0,1,1,0,0,32'hA8,        1,32'h8,1,32'h4,32'hA4));
    vecs.push_back(mk(0,1,1,0,0,32'hAC,        1,32'hC,1,32'h8,32'hA8));
    vecs.push_back(mk(0,0,1,0,0,0,             1,32'h10,1,32'hC,32'hAC));
    vecs.push_back(mk(0,0,1,0,0,0,             1,32'h10,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,32'hB0,        1,32'h0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,32'hB4,        1,32'h4,1,32'h0,32'hB0));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,1,32'h0,32'hB0));
    vecs.push_back(mk(0,0,1,0,0,0,             0,0,1,32'h0,32'hB0));
    vecs.push_back(mk(0,0,0,0,0,0,             1,32'h8,1,32'h4,32'hB4));
    vecs.push_back(mk(0,1,0,1,32'h40,32'hDEAD, 1,32'h8,1,32'h4,32'hB4));
    vecs.push_back(mk(0,0,0,0,0,0,             1,32'h40,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,32'hC40,       1,32'h40,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             1,32'h44,1,32'h40,32'hC40));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("vec%0d bus_req", i), 32'(bus_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d bus_addr", i), bus_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d bus_opt", i), 32'(bus_opt), 32'h2);
      if (vecs[i].e_valid || vecs[i].rst) begin
        chk($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
      end
      next_cycle();
    end

    // Redirect while a read to 4 is outstanding; its ack shows up 3 cycles later.
    drive(1,0,0,0,0,0); next_cycle();
    drive(0,1,0,0,0,32'h11); next_cycle();
    drive(0,0,0,1,32'h103,0);
    @(negedge clk);
    chk("drop pending addr", bus_addr, 32'h4);
    chk("drop pending req", 32'(bus_req), 32'h1);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(0,0,0,0,0,0);
      @(negedge clk);
      chk("drop hold addr", bus_addr, 32'h4);
      chk("drop hold req", 32'(bus_req), 32'h1);
      chk("drop flushed", 32'(inst_valid), 32'h0);
      next_cycle();
    end
    drive(0,1,0,0,0,32'hBAD);
    @(negedge clk);
    chk("drop ack addr", bus_addr, 32'h4);
    next_cycle();
    drive(0,1,0,0,0,32'h22);
    @(negedge clk);
    chk("after drop valid", 32'(inst_valid), 32'h0);
    chk("after drop addr", bus_addr, 32'h100);
    chk("after drop req", 32'(bus_req), 32'h1);
    next_cycle();
    drive(0,0,0,0,0,0);
    @(negedge clk);
    chk("after drop head pc", inst_pc, 32'h100);
    chk("after drop head inst", inst, 32'h22);
    next_cycle();

    // Reset while a read is pending, with an ack in the same cycle.
    drive(1,0,0,0,0,0); next_cycle();
    drive(0,1,1,0,0,32'h1); next_cycle();
    drive(1,1,0,0,0,32'h99);
    @(negedge clk);
    chk("rst mid req bus_req", 32'(bus_req), 32'h0);
    chk("rst mid req valid", 32'(inst_valid), 32'h0);
    next_cycle();
    drive(0,0,0,0,0,0);
    @(negedge clk);
    chk("post rst valid", 32'(inst_valid), 32'h0);
    chk("post rst req", 32'(bus_req), 32'h1);
    chk("post rst addr", bus_addr, 32'h0);
    next_cycle();

    // Fetch PC wrap-around from the top of the address space.
    w_rst = 1'b0; w_ack = 1'b1; w_rdata = 32'h5;
    @(negedge clk);
    chk("wrap first addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap first req", 32'(w_req), 32'h1);
    next_cycle();
    w_rdata = 32'h6;
    @(negedge clk);
    chk("wrap second addr", w_addr, 32'h0);
    chk("wrap head pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap head inst", w_inst, 32'h5);
    next_cycle();
    w_ack = 1'b0; w_ready = 1'b1;
    @(negedge clk);
    chk("wrap full req", 32'(w_req), 32'h0);
    chk("wrap full pc", w_pc, 32'hFFFF_FFFC);
    next_cycle();
    w_ready = 1'b0;
    @(negedge clk);
    chk("wrap next pc", w_pc, 32'h0);
    chk("wrap next inst", w_inst, 32'h6);
    chk("wrap refill addr", w_addr, 32'h4);
    next_cycle();

    // Randomized run against the reference model.
    mq.delete(); m_fetch = 32'h0; m_drop = 0; m_drop_addr = 32'h0;
    drive(1,0,0,0,0,0); next_cycle();
    for (int c = 0; c < 3000; c++) begin
      logic r, rdy, rd, a;
      logic [31:0] rpc, rdata;
      r     = ($urandom_range(99) == 0);
      rdy   = $urandom_range(1);
      rd    = ($urandom_range(11) == 0);
      rpc   = $urandom;
      rdata = $urandom;
      m_req   = !r && (m_drop || mq.size() < 2);
      m_addr  = m_drop ? m_drop_addr : m_fetch;
      m_valid = !r && mq.size() != 0;
      a = m_req && ($urandom_range(1) == 1);
      drive(r, a, rdy, rd, rpc, rdata);
      @(negedge clk);
      chk("rand bus_req", 32'(bus_req), 32'(m_req));
      if (m_req) chk("rand bus_addr", bus_addr, m_addr);
      chk("rand inst_valid", 32'(inst_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rand inst_pc", inst_pc, mq[0].pc);
        chk("rand inst", inst, mq[0].ins);
      end
      @(posedge clk);
      ack_ok = a && m_req;
      if (r) begin
        mq.delete(); m_fetch = 32'h0; m_drop = 0;
      end else if (rd) begin
        mq.delete();
        if (!m_drop && m_req && !a) begin
          m_drop = 1; m_drop_addr = m_fetch;
        end else if (m_drop && ack_ok) begin
          m_drop = 0;
        end
        m_fetch = {rpc[31:2], 2'b00};
      end else if (m_drop) begin
        if (ack_ok) m_drop = 0;
      end else begin
        if (m_valid && rdy) void'(mq.pop_front());
        if (ack_ok) begin
          mq.push_back('{pc: m_fetch, ins: rdata});
          m_fetch = m_fetch + 32'd4;
        end
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
